// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Grant ids double as bit positions in the arbiter's req/gnt vectors.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input writeback arbiter, round-robin or fixed A-over-B priority.
// last_grant moves only when both requesters compete.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       rr_enable,
  output logic [1:0] gnt
);

  gnt_id_e last_q;
  gnt_id_e last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11): begin
          if (rr_enable && last_q == GNT_A) begin
            gnt[REQ_B] = 1'b1;
            last_d     = GNT_B;
          end else begin
            gnt[REQ_A] = 1'b1;
            last_d     = GNT_A;
          end
        end
        (req == 2'b01): gnt[REQ_A] = 1'b1;
        (req == 2'b10): gnt[REQ_B] = 1'b1;
        default:        gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= GNT_B;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B).
// One-entry writeback stage, bypass export and event counters.
module regfile_wb_arbiter #(
  parameter int XLEN       = regfile_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W,
  parameter int RR_ENABLE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [REG_ADDR_W-1:0]    a_rd,
  input  logic [XLEN-1:0]          a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [REG_ADDR_W-1:0]    b_rd,
  input  logic [XLEN-1:0]          b_data,
  input  logic                     wb_hold,
  output logic [REG_ADDR_W-1:0]    rd,
  output logic [XLEN-1:0]          write_data,
  output logic                     write_enable,
  output logic                     fwd_valid,
  output logic [REG_ADDR_W-1:0]    fwd_rd,
  output logic [XLEN-1:0]          fwd_data,
  output logic [2**REG_ADDR_W-1:0] pending_mask,
  output logic [31:0]              write_count,
  output logic [31:0]              conflict_count
);

  import regfile_pkg::*;

  logic [1:0]            gnt;
  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic [31:0]           wcnt_q, wcnt_d;
  logic [31:0]           ccnt_q, ccnt_d;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  // Reset also blocks acceptance so nothing slips in while rst is high.
  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({b_valid, a_valid}),
    .en        (!wb_hold && !rst),
    .rr_enable (RR_ENABLE != 0),
    .gnt       (gnt)
  );

  assign a_ready = gnt[REQ_A];
  assign b_ready = gnt[REQ_B];

  always_comb begin
    sel_rd   = a_rd;
    sel_data = a_data;
    if (gnt[REQ_B]) begin
      sel_rd   = b_rd;
      sel_data = b_data;
    end
  end

  always_comb begin
    valid_d = (|gnt) && (sel_rd != '0);
    rd_d    = valid_d ? sel_rd : rd_q;
    data_d  = valid_d ? sel_data : data_q;
    wcnt_d  = wcnt_q + 32'(valid_q);
    ccnt_d  = ccnt_q + 32'(a_valid && b_valid && !wb_hold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
      ccnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      ccnt_q  <= ccnt_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    if (valid_q) pending_mask[rd_q] = 1'b1;
  end

  assign rd             = rd_q;
  assign write_data     = data_q;
  assign write_enable   = valid_q;
  assign fwd_valid      = valid_q;
  assign fwd_rd         = rd_q;
  assign fwd_data       = data_q;
  assign write_count    = wcnt_q;
  assign conflict_count = ccnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: round-robin DUT plus a fixed-priority twin on the
// same stimulus, checked with immediate assertions.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, wb_hold;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, write_enable, fwd_valid;
  logic [4:0]  rd, fwd_rd;
  logic [31:0] write_data, fwd_data, pending_mask;
  logic [31:0] write_count, conflict_count;

  logic        f_a_ready, f_b_ready, f_we, f_fv;
  logic [4:0]  f_rd, f_frd;
  logic [31:0] f_wd, f_fd, f_pm, f_wc, f_cc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.RR_ENABLE(1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_rd(b_rd), .b_data(b_data),
    .wb_hold(wb_hold),
    .rd(rd), .write_data(write_data),
    .write_enable(write_enable),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data),
    .pending_mask(pending_mask),
    .write_count(write_count),
    .conflict_count(conflict_count)
  );

  regfile_wb_arbiter #(.RR_ENABLE(0)) dut_fp (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(f_a_ready),
    .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(f_b_ready),
    .b_rd(b_rd), .b_data(b_data),
    .wb_hold(wb_hold),
    .rd(f_rd), .write_data(f_wd),
    .write_enable(f_we),
    .fwd_valid(f_fv), .fwd_rd(f_frd),
    .fwd_data(f_fd),
    .pending_mask(f_pm),
    .write_count(f_wc),
    .conflict_count(f_cc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  // Same-rd requests from A and B are illegal upstream.
  always @(negedge clk) begin
    if (!rst && a_valid && b_valid)
      chk("same_rd", 32'(a_rd != b_rd), 32'd1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_a;

    rst = 1'b1; wb_hold = 1'b0;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h44;
    step(); step();
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_wcnt", write_count, 0);
    chk("rst_ccnt", conflict_count, 0);
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_pmask", pending_mask, 0);

    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    step();

    // A-only write to x5
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    chk("a_only_ready", 32'(a_ready), 1);
    chk("a_only_b_ready", 32'(b_ready), 0);
    step();
    a_valid = 1'b0;
    chk("a_only_we", 32'(write_enable), 1);
    chk("a_only_rd", 32'(rd), 5);
    chk("a_only_data", write_data, 32'hDEADBEEF);
    chk("a_only_fwd_valid", 32'(fwd_valid), 1);
    chk("a_only_fwd_rd", 32'(fwd_rd), 5);
    chk("a_only_fwd_data", fwd_data, 32'hDEADBEEF);
    chk("a_only_pmask", pending_mask, 32'h20);
    step();
    chk("a_only_wcnt", write_count, 1);
    chk("a_only_we_off", 32'(write_enable), 0);
    chk("a_only_pmask_off", pending_mask, 0);
    chk("a_only_rd_hold", 32'(rd), 5);

    // Four-cycle conflict: RR alternates A,B,A,B
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      chk("rr_a_ready", 32'(a_ready), 32'(exp_a));
      chk("rr_b_ready", 32'(b_ready), 32'(!exp_a));
      chk("fp_a_ready", 32'(f_a_ready), 1);
      chk("fp_b_ready", 32'(f_b_ready), 0);
      step();
      chk("rr_rd", 32'(rd), exp_a ? 32'd1 : 32'd2);
      chk("rr_data", write_data, exp_a ? 32'h11 : 32'h22);
      chk("fp_rd", 32'(f_rd), 1);
    end
    chk("rr_ccnt", conflict_count, 4);
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("rr_wcnt", write_count, 5);
    chk("rr_we_off", 32'(write_enable), 0);

    // B writes x0: handshake completes, no write
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h1234;
    #1;
    chk("x0_b_ready", 32'(b_ready), 1);
    step();
    b_valid = 1'b0;
    chk("x0_we", 32'(write_enable), 0);
    chk("x0_pmask", pending_mask, 0);
    step();
    chk("x0_wcnt", write_count, 5);

    // wb_hold with both valid
    wb_hold = 1'b1;
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_a_ready", 32'(a_ready), 0);
      chk("hold_b_ready", 32'(b_ready), 0);
      step();
      chk("hold_we", 32'(write_enable), 0);
    end
    chk("hold_ccnt", conflict_count, 4);
    chk("hold_wcnt", write_count, 5);
    wb_hold = 1'b0;
    #1;
    chk("release_a_ready", 32'(a_ready), 1);
    chk("release_b_ready", 32'(b_ready), 0);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("release_ccnt", conflict_count, 5);
    chk("release_rd", 32'(rd), 1);

    // Reset while a write to x7 is in flight
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    step();
    a_valid = 1'b0;
    chk("inflight_we", 32'(write_enable), 1);
    chk("inflight_rd", 32'(rd), 7);
    chk("inflight_wcnt", write_count, 6);
    rst = 1'b1;
    step();
    chk("rst_flight_we", 32'(write_enable), 0);
    chk("rst_flight_wcnt", write_count, 0);
    chk("rst_flight_pmask", pending_mask, 0);
    chk("rst_flight_rd", 32'(rd), 0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
